tt_um_digit_ota_display: RTL and testbench

Receiving end of the Digit_OTA byte path: where the existing top presents an 8-bit binary sum on its pins, this tile accepts an 8-bit binary value on `ui_in` with a strobe. It converts the value to three BCD digits with an iterative double-dabble engine. It then drives a multiplexed, common-anode-agnostic 7-segment display (hundreds/tens/ones) with leading-zero blanking. It is a standalone TinyTapeout user tile with one clock domain.

---
 rtl/tt_um_digit_ota_display.sv | 214 +++++++++++++++++++++
 tb/tb_tt_um_digit_ota_display.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/tt_um_digit_ota_display.sv
// tt_um_digit_ota_display
// Receives an 8-bit binary value with a strobe and converts it to three BCD
// digits with an iterative double-dabble engine. The digits are shown on a
// multiplexed 7-segment display with leading-zero blanking.
//
// Ports:
//   ui_in   [7:0] binary value, sampled on the load event
//   uio_in  [7:0] bit 0 = load strobe (asynchronous), bits 7:1 unused
//   uo_out  [7:0] bits 6:0 = segments a..g (active high), bit 7 = dp (0)
//   uio_out [7:0] bit 1 = busy, bits 4:2 = digit select {hund, tens, ones}
//   uio_oe  [7:0] constant 8'hFE
//   ena           unused
//   clk, rst_n    clock, asynchronous active-low reset
module tt_um_digit_ota_display #(
  parameter int unsigned MUX_DIV = 1024
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int unsigned CNT_W = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MUX_DIV - 1);

  localparam logic [1:0] DIG_ONES = 2'd0;
  localparam logic [1:0] DIG_TENS = 2'd1;
  localparam logic [1:0] DIG_HUND = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // Strobe synchronizer and edge detector
  logic strb_s1, strb_s2, strb_prev;
  logic load_evt;

  // Conversion engine
  state_t     state_q, state_d;
  logic [7:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [11:0] bcd_adj;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [11:0] disp_q, disp_d;
  logic        busy_q;

  // Scan and output registers
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]       dig_idx_q, dig_idx_d;
  logic [3:0]       dig_nib;
  logic             dig_blank;
  logic [6:0]       seg_q, seg_d;
  logic [2:0]       sel_q, sel_d;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:1]};

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? 4'(n + 4'd3) : n;
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Two-flop synchronizer plus previous-value flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_s1   <= 1'b0;
      strb_s2   <= 1'b0;
      strb_prev <= 1'b0;
    end else begin
      strb_s1   <= uio_in[0];
      strb_s2   <= strb_s1;
      strb_prev <= strb_s2;
    end
  end

  assign load_evt = strb_s2 & ~strb_prev;

  // Per-nibble add-3 correction applied before each shift
  assign bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};

  // FSM state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bin_q     <= 8'h00;
      bcd_q     <= 12'h000;
      bit_cnt_q <= 3'd0;
      disp_q    <= 12'h000;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      bit_cnt_q <= bit_cnt_d;
      disp_q    <= disp_d;
      busy_q    <= (state_d == CONV);
    end
  end

  // Next-state and datapath logic; load events during CONV are dropped
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    bit_cnt_d = bit_cnt_q;
    disp_d    = disp_q;
    case (state_q)
      IDLE: begin
        if (load_evt) begin
          bin_d     = ui_in;
          bcd_d     = 12'h000;
          bit_cnt_d = 3'd0;
          state_d   = CONV;
        end
      end
      CONV: begin
        bcd_d     = {bcd_adj[10:0], bin_q[7]};
        bin_d     = {bin_q[6:0], 1'b0};
        bit_cnt_d = 3'(bit_cnt_q + 3'd1);
        if (bit_cnt_q == 3'd7) begin
          disp_d  = {bcd_adj[10:0], bin_q[7]};
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-running scan counter and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      dig_idx_q  <= DIG_ONES;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      dig_idx_q  <= dig_idx_d;
    end
  end

  always_comb begin
    scan_cnt_d = CNT_W'(scan_cnt_q + CNT_W'(1));
    dig_idx_d  = dig_idx_q;
    if (scan_cnt_q == CNT_MAX) begin
      scan_cnt_d = '0;
      case (dig_idx_q)
        DIG_ONES: dig_idx_d = DIG_TENS;
        DIG_TENS: dig_idx_d = DIG_HUND;
        default:  dig_idx_d = DIG_ONES;
      endcase
    end
  end

  // Digit select, leading-zero blanking and segment encoding
  always_comb begin
    dig_nib   = disp_q[3:0];
    dig_blank = 1'b0;
    sel_d     = 3'b001;
    case (dig_idx_q)
      DIG_TENS: begin
        dig_nib   = disp_q[7:4];
        dig_blank = (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0);
        sel_d     = 3'b010;
      end
      DIG_HUND: begin
        dig_nib   = disp_q[11:8];
        dig_blank = (disp_q[11:8] == 4'd0);
        sel_d     = 3'b100;
      end
      default: begin
        dig_nib   = disp_q[3:0];
        dig_blank = 1'b0;
        sel_d     = 3'b001;
      end
    endcase
    seg_d = dig_blank ? 7'h00 : seg_enc(dig_nib);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= 7'h00;
      sel_q <= 3'b000;
    end else begin
      seg_q <= seg_d;
      sel_q <= sel_d;
    end
  end

  assign uo_out  = {1'b0, seg_q};
  assign uio_out = {3'b000, sel_q, busy_q, 1'b0};
  assign uio_oe  = 8'hFE;

endmodule

// File: tb/tb_tt_um_digit_ota_display.sv
// Directed testbench for tt_um_digit_ota_display with MUX_DIV = 4.
module tb_tt_um_digit_ota_display;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  tt_um_digit_ota_display #(.MUX_DIV(4)) dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe a value (called at a negedge) and watch busy over a window
  task automatic run_load(input logic [7:0] val, input int hold,
                          input int coll_at, input logic [7:0] coll_val,
                          input int window, output int first,
                          output int ncyc, output int npulses);
    logic busy;
    logic prev_b;
    prev_b  = 1'b0;
    first   = -1;
    ncyc    = 0;
    npulses = 0;
    ui_in     = val;
    uio_in[0] = 1'b1;
    for (int i = 1; i <= window; i++) begin
      @(negedge clk);
      busy = uio_out[1];
      if (busy) begin
        ncyc++;
        if (!prev_b) begin
          npulses++;
          if (first < 0) first = i;
        end
      end
      prev_b = busy;
      if (i == hold) uio_in[0] = 1'b0;
      if (coll_at > 0 && i == coll_at) begin
        ui_in     = coll_val;
        uio_in[0] = 1'b1;
      end
      if (coll_at > 0 && i == coll_at + 2) uio_in[0] = 1'b0;
    end
  endtask

  // Scan 16 cycles; check segments per select, rotation order and dwell
  task automatic check_display(input string tag, input logic [6:0] eh,
                               input logic [6:0] et, input logic [6:0] eo);
    logic [2:0] sel, last_sel, exp_next;
    logic [6:0] exp_seg;
    int run;
    bit started;
    last_sel = 3'b000;
    run      = 0;
    started  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      sel = uio_out[4:2];
      case (sel)
        3'b001:  exp_seg = eo;
        3'b010:  exp_seg = et;
        3'b100:  exp_seg = eh;
        default: exp_seg = 7'h7F;
      endcase
      check({tag, "_onehot"}, int'($onehot(sel)), 1);
      check({tag, "_seg"}, int'(uo_out), int'({1'b0, exp_seg}));
      if (i > 0 && sel != last_sel) begin
        exp_next = (last_sel == 3'b100) ? 3'b001 : 3'(last_sel << 1);
        check({tag, "_order"}, int'(sel), int'(exp_next));
        if (started) check({tag, "_dwell"}, run, 4);
        started = 1'b1;
        run     = 1;
      end else begin
        run++;
      end
      last_sel = sel;
    end
  endtask

  initial begin
    int first, ncyc, npulses;
    bit seen;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_uo_out", int'(uo_out), 8'h00);
    check("rst_uio_out", int'(uio_out), 8'h00);
    check("rst_uio_oe", int'(uio_oe), 8'hFE);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_uo_out", int'(uo_out), 8'h3F);
    check("post_rst_uio_out", int'(uio_out), 8'h04);
    check_display("zero", 7'h00, 7'h00, 7'h3F);

    // Load 255
    run_load(8'hFF, 4, 0, 8'h00, 20, first, ncyc, npulses);
    check("l255_busy_start", int'(first >= 3 && first <= 4), 1);
    check("l255_busy_len", ncyc, 8);
    check("l255_pulses", npulses, 1);
    check_display("d255", 7'h5B, 7'h6D, 7'h6D);

    // Load 7: tens and hundreds blank
    run_load(8'd7, 2, 0, 8'h00, 16, first, ncyc, npulses);
    check("l7_busy_len", ncyc, 8);
    check_display("d7", 7'h00, 7'h00, 7'h07);

    // Load 105: inner zero not blanked
    run_load(8'd105, 2, 0, 8'h00, 16, first, ncyc, npulses);
    check("l105_busy_len", ncyc, 8);
    check_display("d105", 7'h06, 7'h3F, 7'h6D);

    // Load 42 with a second strobe (99) while busy
    run_load(8'd42, 2, 5, 8'd99, 30, first, ncyc, npulses);
    check("coll_busy_len", ncyc, 8);
    check("coll_pulses", npulses, 1);
    check_display("d42", 7'h00, 7'h66, 7'h5B);

    // Strobe held high for 100 cycles loads once
    run_load(8'd12, 100, 0, 8'h00, 110, first, ncyc, npulses);
    check("held_busy_start", int'(first >= 3 && first <= 4), 1);
    check("held_busy_len", ncyc, 8);
    check("held_pulses", npulses, 1);
    check_display("d12", 7'h00, 7'h06, 7'h5B);

    // Reset during busy cycle 4 aborts the conversion of 200
    ui_in     = 8'd200;
    uio_in[0] = 1'b1;
    seen      = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = uio_out[1];
    end
    check("abort_busy_seen", int'(seen), 1);
    repeat (3) @(negedge clk);
    uio_in[0] = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("abort_uo_out", int'(uo_out), 8'h00);
    check("abort_uio_out", int'(uio_out), 8'h00);
    check("abort_uio_oe", int'(uio_oe), 8'hFE);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_not_busy", int'(uio_out[1]), 0);
    check_display("abort", 7'h00, 7'h00, 7'h3F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
